shift_rx8: RTL and testbench

- Serial-in, parallel-out receive shift register: the receiving end of the team's 8-bit logical shifter.
- After `start`, collects 1..8 serial bits, one per accepted `sin_valid` beat.
- Direction matches the shifter convention: dir=0 is a left shift, dir=1 is a right shift.
- Publishes the assembled word on `q` with a one-cycle `done` pulse; sits between a serial source and downstream parallel logic.

---
 rtl/shift_rx8_pkg.sv | 16 +
 rtl/shift_rx8_core.sv | 62 ++++++
 rtl/shift_rx8.sv | 100 ++++++++++
 tb/tb_shift_rx8.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/shift_rx8_pkg.sv
// rtl/shift_rx8_pkg.sv - shared state encodings, direction constants, width and seed for shift_rx8
package shift_rx8_pkg;

  localparam int         SH_WIDTH = 8;
  localparam logic [7:0] SH_SEED  = 8'b01100110;

  localparam logic SH_LEFT  = 1'b0;
  localparam logic SH_RIGHT = 1'b1;

  typedef enum logic [1:0] {
    SH_IDLE = 2'd0,
    SH_RECV = 2'd1,
    SH_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/shift_rx8_core.sv
// rtl/shift_rx8_core.sv - shadow shift register and bit counter with clamped terminal count
module shift_rx_core
  import shift_rx8_pkg::*;
#(
  parameter int               WIDTH    = SH_WIDTH,
  parameter int               CNT_W    = 4,
  parameter logic [WIDTH-1:0] INIT_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dir,
  input  logic [CNT_W-1:0] nbits,
  input  logic             shift_en,
  input  logic             sin,
  output logic [WIDTH-1:0] shadow_next,
  output logic             hit
);

  logic [WIDTH-1:0] shadow;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] n_eff;
  logic [CNT_W-1:0] n_r;
  logic             dir_r;

  // Zero or oversize requests mean a full word.
  always_comb begin
    n_eff = nbits;
    if (nbits == '0 || nbits > CNT_W'(WIDTH)) begin
      n_eff = CNT_W'(WIDTH);
    end
  end

  always_comb begin
    shadow_next = {shadow[WIDTH-2:0], sin};
    if (dir_r == SH_RIGHT) begin
      shadow_next = {sin, shadow[WIDTH-1:1]};
    end
  end

  // True when the next accepted beat completes the word.
  assign hit = ((cnt + CNT_W'(1)) == n_r);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow <= INIT_VAL;
      cnt    <= '0;
      n_r    <= CNT_W'(WIDTH);
      dir_r  <= SH_LEFT;
    end else if (load) begin
      shadow <= load_val;
      cnt    <= '0;
      n_r    <= n_eff;
      dir_r  <= dir;
    end else if (shift_en) begin
      shadow <= shadow_next;
      cnt    <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/shift_rx8.sv
// rtl/shift_rx8.sv - serial-in parallel-out receiver; SHIFT_RX_INIT_PATTERN_EN seeds q and shifts into it
module shift_rx8
  import shift_rx8_pkg::*;
#(
  parameter int WIDTH = SH_WIDTH,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             dir,
  input  logic [CNT_W-1:0] nbits,
  input  logic             sin,
  input  logic             sin_valid,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done,
  output logic             err
);

`ifdef SHIFT_RX_INIT_PATTERN_EN
  localparam logic [WIDTH-1:0] INIT_VAL = WIDTH'(SH_SEED);
`else
  localparam logic [WIDTH-1:0] INIT_VAL = '0;
`endif

  state_t           state, state_next;
  logic             load;
  logic             shift_en;
  logic             hit;
  logic [WIDTH-1:0] shadow_next;
  logic [WIDTH-1:0] load_val;

`ifdef SHIFT_RX_INIT_PATTERN_EN
  assign load_val = q;
`else
  assign load_val = '0;
`endif

  shift_rx_core #(
    .WIDTH    (WIDTH),
    .CNT_W    (CNT_W),
    .INIT_VAL (INIT_VAL)
  ) u_core (
    .clk         (clk),
    .rst_n       (rst_n),
    .load        (load),
    .load_val    (load_val),
    .dir         (dir),
    .nbits       (nbits),
    .shift_en    (shift_en),
    .sin         (sin),
    .shadow_next (shadow_next),
    .hit         (hit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= SH_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    shift_en   = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      SH_IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = SH_RECV;
        end
      end
      SH_RECV: begin
        busy     = 1'b1;
        shift_en = sin_valid;
        if (sin_valid && hit) state_next = SH_DONE;
      end
      SH_DONE: begin
        done       = 1'b1;
        state_next = SH_IDLE;
      end
      default: state_next = SH_IDLE;
    endcase
  end

  // q captures the word on the final beat so it is already valid while done is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              q <= INIT_VAL;
    else if (shift_en && hit) q <= shadow_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          err <= 1'b0;
    else if (load)                       err <= 1'b0;
    else if (state == SH_RECV && start)  err <= 1'b1;
  end

endmodule

// File: tb/tb_shift_rx8.sv
// tb/tb_shift_rx8.sv - directed self-checking bench for shift_rx8
module tb_shift_rx8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       dir = 1'b0;
  logic [3:0] nbits = 4'd0;
  logic       sin = 1'b0;
  logic       sin_valid = 1'b0;
  logic [7:0] q;
  logic       busy, done, err;

  int checks = 0;
  int failures = 0;

  int         r_busy, r_done_at, r_done_cnt;
  logic [7:0] r_q;

`ifdef SHIFT_RX_INIT_PATTERN_EN
  localparam logic [7:0] RST_Q  = 8'h66;
  localparam logic [7:0] SEED_Q = 8'h9B;
`else
  localparam logic [7:0] RST_Q  = 8'h00;
  localparam logic [7:0] SEED_Q = 8'h03;
`endif

  always #5 clk = ~clk;

  shift_rx8 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .dir       (dir),
    .nbits     (nbits),
    .sin       (sin),
    .sin_valid (sin_valid),
    .q         (q),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  // bits[7] is sent first; gaps[k] inserts one idle cycle before bit k.
  task automatic run_rx(input logic d, input logic [3:0] nb, input int n,
                        input logic [7:0] bits, input logic [7:0] gaps, input int start_at);
    int k = 0;
    bit gap_used = 1'b0;
    r_busy = 0; r_done_at = -1; r_done_cnt = 0; r_q = 8'hxx;
    @(posedge clk); #1;
    start = 1'b1; dir = d; nbits = nb;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 40; c++) begin
      start = (c == start_at);
      if (k < n) begin
        if (gaps[k] && !gap_used) begin
          sin_valid = 1'b0; gap_used = 1'b1;
        end else begin
          sin_valid = 1'b1; sin = bits[7-k]; k++; gap_used = 1'b0;
        end
      end else begin
        sin_valid = 1'b0; sin = 1'b0;
      end
      @(negedge clk);
      if (busy) r_busy++;
      if (done) begin
        r_done_cnt++;
        if (r_done_at < 0) begin r_done_at = c; r_q = q; end
      end
      @(posedge clk); #1;
      if (r_done_at >= 0 && c >= r_done_at + 1) break;
    end
    start = 1'b0; sin_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (q !== RST_Q)  begin failures++; $display("FAIL reset_q: got %h want %h", q, RST_Q); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (err !== 1'b0)  begin failures++; $display("FAIL reset_err: got %b want 0", err); end
    @(posedge clk); #1; rst_n = 1'b1;
  endtask

  task automatic test_seed();
    run_rx(1'b0, 4'd2, 2, 8'b11000000, 8'h00, -1);
    checks++; if (r_q !== SEED_Q) begin failures++; $display("FAIL seed_q: got %h want %h", r_q, SEED_Q); end
    checks++; if (r_done_at !== 2) begin failures++; $display("FAIL seed_done_at: got %0d want 2", r_done_at); end
  endtask

  task automatic test_left8();
    run_rx(1'b0, 4'd8, 8, 8'b10110010, 8'h00, -1);
    checks++; if (r_q !== 8'hB2)   begin failures++; $display("FAIL left8_q: got %h want b2", r_q); end
    checks++; if (r_done_at !== 8) begin failures++; $display("FAIL left8_done_at: got %0d want 8", r_done_at); end
    checks++; if (r_busy !== 8)    begin failures++; $display("FAIL left8_busy: got %0d want 8", r_busy); end
    checks++; if (r_done_cnt !== 1) begin failures++; $display("FAIL left8_done_cnt: got %0d want 1", r_done_cnt); end
    @(negedge clk);
    checks++; if (q !== 8'hB2) begin failures++; $display("FAIL left8_q_hold: got %h want b2", q); end
  endtask

  task automatic test_right8();
    run_rx(1'b1, 4'd8, 8, 8'b10110010, 8'h00, -1);
    checks++; if (r_q !== 8'h4D)   begin failures++; $display("FAIL right8_q: got %h want 4d", r_q); end
    checks++; if (r_done_at !== 8) begin failures++; $display("FAIL right8_done_at: got %0d want 8", r_done_at); end
  endtask

  task automatic test_partial();
    run_rx(1'b1, 4'd3, 3, 8'b11000000, 8'h00, -1);
    checks++; if (r_q !== 8'h60)   begin failures++; $display("FAIL part3_q: got %h want 60", r_q); end
    checks++; if (r_done_at !== 3) begin failures++; $display("FAIL part3_done_at: got %0d want 3", r_done_at); end
    checks++; if (r_busy !== 3)    begin failures++; $display("FAIL part3_busy: got %0d want 3", r_busy); end
    run_rx(1'b0, 4'd0, 8, 8'b10110010, 8'h00, -1);
    checks++; if (r_q !== 8'hB2)   begin failures++; $display("FAIL nb0_q: got %h want b2", r_q); end
    checks++; if (r_done_at !== 8) begin failures++; $display("FAIL nb0_done_at: got %0d want 8", r_done_at); end
    run_rx(1'b1, 4'd15, 8, 8'b10110010, 8'h00, -1);
    checks++; if (r_q !== 8'h4D)   begin failures++; $display("FAIL nb15_q: got %h want 4d", r_q); end
    checks++; if (r_done_at !== 8) begin failures++; $display("FAIL nb15_done_at: got %0d want 8", r_done_at); end
  endtask

  task automatic test_gaps();
    run_rx(1'b0, 4'd8, 8, 8'b10110010, 8'b00100100, -1);
    checks++; if (r_q !== 8'hB2)    begin failures++; $display("FAIL gaps_q: got %h want b2", r_q); end
    checks++; if (r_done_at !== 10) begin failures++; $display("FAIL gaps_done_at: got %0d want 10", r_done_at); end
    checks++; if (r_busy !== 10)    begin failures++; $display("FAIL gaps_busy: got %0d want 10", r_busy); end
  endtask

  task automatic test_start_busy();
    run_rx(1'b0, 4'd8, 8, 8'b10110010, 8'h00, 3);
    checks++; if (r_q !== 8'hB2)   begin failures++; $display("FAIL sbusy_q: got %h want b2", r_q); end
    checks++; if (r_done_at !== 8) begin failures++; $display("FAIL sbusy_done_at: got %0d want 8", r_done_at); end
    @(negedge clk);
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL sbusy_err_set: got %b want 1", err); end
    run_rx(1'b1, 4'd3, 3, 8'b11000000, 8'h00, -1);
    checks++; if (err !== 1'b0)  begin failures++; $display("FAIL sbusy_err_clr: got %b want 0", err); end
    checks++; if (r_q !== 8'h60) begin failures++; $display("FAIL sbusy_next_q: got %h want 60", r_q); end
  endtask

  task automatic test_start_in_done();
    run_rx(1'b0, 4'd8, 8, 8'b10110010, 8'h00, 8);
    checks++; if (r_q !== 8'hB2) begin failures++; $display("FAIL sdone_q: got %h want b2", r_q); end
    @(negedge clk);
    checks++; if (err !== 1'b0)  begin failures++; $display("FAIL sdone_err: got %b want 0", err); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL sdone_busy: got %b want 0", busy); end
  endtask

  task automatic test_reset_mid();
    int dcnt = 0;
    @(posedge clk); #1;
    start = 1'b1; dir = 1'b0; nbits = 4'd8;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sin_valid = 1'b1; sin = i[0];
      @(posedge clk); #1;
    end
    sin_valid = 1'b0;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rmid_busy_pre: got %b want 1", busy); end
    rst_n = 1'b0; #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rmid_busy: got %b want 0", busy); end
    checks++; if (q !== RST_Q)   begin failures++; $display("FAIL rmid_q: got %h want %h", q, RST_Q); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL rmid_done: got %b want 0", done); end
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    checks++; if (dcnt !== 0) begin failures++; $display("FAIL rmid_no_done: got %0d want 0", dcnt); end
  endtask

  initial begin
    test_reset();
    test_seed();
    test_left8();
    test_right8();
    test_partial();
    test_gaps();
    test_start_busy();
    test_start_in_done();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
